// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter
//
// Shares one line-wide memory port between the ifetch requester (i_*) and the
// data requester (d_*). Data is preferred. An ifetch that has been passed over
// STARVE_LIMIT times in a row wins the next conflict. The downstream request is
// registered and held stable until mem_resp. Every transaction is followed by at
// least one IDLE turnaround cycle.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_read/i_address            ifetch line read request (level)
//   i_rdata/i_resp              ifetch read data (passthrough), completion pulse
//   d_read/d_write/d_address    data request (level); read+write is treated as write
//   d_wdata/d_sel               data write line and byte selects
//   d_rdata/d_resp              data read data (passthrough), completion pulse
//   mem_*                       downstream request (registered) and response
//
// Optional feature: define ARB_PERF_CNT_EN to add the saturating 16-bit
// perf_i_grants, perf_d_grants and perf_conflicts outputs.
module line_mem_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned LINE_W       = 128,
  parameter int unsigned SEL_W        = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic [SEL_W-1:0]  d_sel,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  output logic [SEL_W-1:0]  mem_sel,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       perf_i_grants,
  output logic [15:0]       perf_d_grants,
  output logic [15:0]       perf_conflicts
`endif
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e          state_q;
  logic [CntW-1:0] starve_q;
  logic            d_req;
  logic            grant_i;
  logic            grant_d;

  // Grant decision, only acted upon in StIdle.
  always_comb begin
    d_req   = d_read | d_write;
    grant_i = i_read & (~d_req | (starve_q == StarveMax));
    grant_d = d_req & ~grant_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_sel     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_i) begin
            state_q     <= StServeI;
            starve_q    <= '0;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
            mem_address <= i_address;
            mem_wdata   <= '0;
            mem_sel     <= '1;  // ifetch always reads the whole line
          end else if (grant_d) begin
            state_q     <= StServeD;
            // Count only D grants that actually pass over a waiting ifetch.
            if (!i_read) begin
              starve_q <= '0;
            end else if (starve_q != StarveMax) begin
              starve_q <= starve_q + 1'b1;
            end
            // Illegal read+write collapses to a write.
            mem_read    <= d_read & ~d_write;
            mem_write   <= d_write;
            mem_address <= d_address;
            mem_wdata   <= d_wdata;
            mem_sel     <= d_sel;
          end
        end
        StServeI, StServeD: begin
          // Request fields stay frozen until the memory answers.
          if (mem_resp) begin
            state_q   <= StIdle;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    i_rdata = mem_rdata;
    d_rdata = mem_rdata;
    i_resp  = (state_q == StServeI) & mem_resp;
    d_resp  = (state_q == StServeD) & mem_resp;
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else if (state_q == StIdle) begin
      if (grant_i && perf_i_grants != 16'hFFFF) begin
        perf_i_grants <= perf_i_grants + 16'd1;
      end
      if (grant_d && perf_d_grants != 16'hFFFF) begin
        perf_d_grants <= perf_d_grants + 16'd1;
      end
      if (i_read && d_req && perf_conflicts != 16'hFFFF) begin
        perf_conflicts <= perf_conflicts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_mem_arbiter.sv
module tb_line_mem_arbiter;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned SEL_W  = 16;
  localparam int unsigned LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [SEL_W-1:0]  d_sel;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [SEL_W-1:0]  mem_sel;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]       perf_i_grants;
  logic [15:0]       perf_d_grants;
  logic [15:0]       perf_conflicts;
`endif

  line_mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .LINE_W      (LINE_W),
    .SEL_W       (SEL_W),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_sel      (d_sel),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_sel    (mem_sel),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_i_grants (perf_i_grants),
    .perf_d_grants (perf_d_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: pending requests, data request kind (1 rd, 2 wr, 3 rd+wr),
  // consecutive passed-over count, and grant statistics.
  bit i_pend;
  bit d_pend;
  int d_kind;
  int m_starve;
  int m_i_grants;
  int m_d_grants;
  int m_conflicts;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_inputs();
    i_address = ADDR_W'($urandom);
    d_address = ADDR_W'($urandom);
    d_wdata   = rand_line();
    d_sel     = SEL_W'($urandom);
    mem_rdata = rand_line();
  endtask

  task automatic drive_reqs();
    i_read  = i_pend;
    d_read  = d_pend && (d_kind != 2);
    d_write = d_pend && (d_kind >= 2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_pend = 0; d_pend = 0; d_kind = 1; m_starve = 0;
    m_i_grants = 0; m_d_grants = 0; m_conflicts = 0;
    drive_reqs();
    mem_resp = 1'b0;
    rand_inputs();
    tick();
    tick();
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_sel", mem_sel, 0);
    rst_n = 1'b1;
  endtask

  // One full transaction, starting at a cycle in which the DUT is idle.
  task automatic do_txn(input bit new_i, input bit new_d, input int kind, input int lat,
                        input bit idle_resp, output bit won_i);
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_wdata;
    logic [SEL_W-1:0]  exp_sel;
    bit                exp_wr;
    if (new_i) i_pend = 1;
    if (new_d && !d_pend) begin
      d_pend = 1;
      d_kind = (kind == 0) ? int'($urandom_range(1, 3)) : kind;
    end
    drive_reqs();
    rand_inputs();
    mem_resp = idle_resp;  // a response while idle must be ignored
    #1;
    check("idle_i_resp", i_resp, 0);
    check("idle_d_resp", d_resp, 0);
    check("idle_mem_read", mem_read, 0);
    check("idle_mem_write", mem_write, 0);

    won_i     = i_pend && (!d_pend || m_starve == LIMIT);
    exp_addr  = won_i ? i_address : d_address;
    exp_wdata = d_wdata;
    exp_sel   = d_sel;
    exp_wr    = !won_i && d_kind >= 2;
    if (i_pend && d_pend) m_conflicts++;
    if (won_i) begin
      m_starve = 0;
      m_i_grants++;
    end else begin
      m_starve = i_pend ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      m_d_grants++;
    end

    tick();
    mem_resp = 1'b0;
    check("grant_mem_read", mem_read, !exp_wr);
    check("grant_mem_write", mem_write, exp_wr);
    check("grant_mem_address", mem_address, exp_addr);
    if (!won_i) begin
      check("grant_mem_wdata", mem_wdata, exp_wdata);
      check("grant_mem_sel", mem_sel, exp_sel);
    end

    repeat (lat) begin
      rand_inputs();
      #1;
      check("wait_i_resp", i_resp, 0);
      check("wait_d_resp", d_resp, 0);
      check("hold_mem_address", mem_address, exp_addr);
      check("hold_mem_write", mem_write, exp_wr);
      if (!won_i) check("hold_mem_wdata", mem_wdata, exp_wdata);
      tick();
    end

    rand_inputs();
    mem_resp = 1'b1;
    #1;
    check("resp_i_resp", i_resp, won_i);
    check("resp_d_resp", d_resp, !won_i);
    check("resp_i_rdata", i_rdata, mem_rdata);
    check("resp_d_rdata", d_rdata, mem_rdata);

    tick();
    mem_resp = 1'b0;
    if (won_i) i_pend = 0;
    else d_pend = 0;
    drive_reqs();
    check("turn_mem_read", mem_read, 0);
    check("turn_mem_write", mem_write, 0);
  endtask

  initial begin
    bit w;
    bit ni;
    bit nd;
    bit exp_order [6] = '{0, 0, 0, 0, 1, 0};

    do_reset();

    // Single ifetch, then a data write held across 5 wait cycles.
    do_txn(1, 0, 0, 2, 0, w);
    check("single_ifetch_won_i", w, 1);
    do_txn(0, 1, 2, 5, 0, w);
    check("data_write_won_d", w, 0);

    // Collision: D first, then I after the turnaround.
    do_txn(1, 1, 1, 1, 0, w);
    check("collide_first", w, 0);
    do_txn(0, 0, 0, 0, 0, w);
    check("collide_second", w, 1);

    // Reset while a write is in service.
    do_reset();
    d_write = 1'b1; d_read = 1'b0;
    d_address = 12'h3A0; d_sel = 16'h0003;
    tick();
    check("pre_rst_mem_write", mem_write, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_write", mem_write, 0);
    check("async_rst_mem_address", mem_address, 0);
    tick();
    rst_n = 1'b1;
    d_write = 1'b0;
    tick();
    mem_resp = 1'b1;
    #1;
    check("late_resp_d_resp", d_resp, 0);
    check("late_resp_i_resp", i_resp, 0);
    tick();
    mem_resp = 1'b0;
    check("late_resp_mem_write", mem_write, 0);

    // Starvation: ifetch held, data re-requested after every response.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      do_txn(1, 1, 1, k % 3, 0, w);
      check("starve_order", w, exp_order[k]);
`ifdef ARB_PERF_CNT_EN
      if (k == 4) begin
        check("perf_d_grants_starve", perf_d_grants, 4);
        check("perf_i_grants_starve", perf_i_grants, 1);
        check("perf_conflicts_starve", perf_conflicts, 5);
      end
`endif
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 200; n++) begin
      ni = 1'($urandom_range(0, 1));
      nd = 1'($urandom_range(0, 1));
      if (!i_pend && !d_pend && !ni && !nd) nd = 1;
      do_txn(ni, nd, 0, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), w);
    end

`ifdef ARB_PERF_CNT_EN
    check("perf_i_grants_final", perf_i_grants, 16'(m_i_grants));
    check("perf_d_grants_final", perf_d_grants, 16'(m_d_grants));
    check("perf_conflicts_final", perf_conflicts, 16'(m_conflicts));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
